// File: rtl/v9_peak_detector_if.sv
// v9_peak_detector_if -- output record channel of the v9 peak detector.
//   peak_valid  : record available (master -> slave)
//   peak_ready  : consumer accepts record (slave -> master)
//   peak_amp    : signed pulse maximum
//   peak_time   : timestamp of the maximum
//   peak_pileup : record flagged as pileup
interface v9_peak_detector_if #(
  parameter int DATA_W = 16,
  parameter int TS_W   = 32
);
  logic                     peak_valid;
  logic                     peak_ready;
  logic signed [DATA_W-1:0] peak_amp;
  logic [TS_W-1:0]          peak_time;
  logic                     peak_pileup;

  modport master (
    output peak_valid, peak_amp, peak_time, peak_pileup,
    input  peak_ready
  );

  modport slave (
    input  peak_valid, peak_amp, peak_time, peak_pileup,
    output peak_ready
  );
endinterface

// File: rtl/v9_peak_detector.sv
// v9_peak_detector -- scans the shaped filter output for pulses above a
// programmable threshold, tracks each pulse maximum and emits one
// amplitude + timestamp record per qualified pulse through a single-entry
// valid/ready output register.
//
// Ports:
//   clk         : clock, rising edge
//   reset       : asynchronous, active-low reset
//   filter_data : signed shaped sample, one per clock
//   threshold   : signed trigger level (quasi-static)
//   enable      : detection enable; low forces IDLE
//   pk          : record channel (v9_peak_detector_if.master)
//   drop_cnt    : events lost to backpressure (saturating)
//   pileup_cnt  : crossings seen during holdoff (saturating)
//   busy        : FSM not in IDLE
//
// Optional feature macro: PEAK_PILEUP_EN -- crossings during holdoff are
// counted, restart the holdoff and flag a still-held record as pileup.
// Without it peak_pileup and pileup_cnt are constant 0.
module v9_peak_detector #(
  parameter int DATA_W    = 16,
  parameter int TS_W      = 32,
  parameter int HOLDOFF   = 16,
  parameter int MIN_WIDTH = 2,
  parameter int CNT_W     = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic signed [DATA_W-1:0] filter_data,
  input  logic signed [DATA_W-1:0] threshold,
  input  logic                     enable,
  v9_peak_detector_if.master       pk,
  output logic [CNT_W-1:0]         drop_cnt,
  output logic [CNT_W-1:0]         pileup_cnt,
  output logic                     busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ARMED = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;

  localparam int         HC_W      = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
  localparam logic [HC_W-1:0] HOLD_INIT = HC_W'(HOLDOFF - 1);
  localparam logic [7:0] MINW      = 8'(MIN_WIDTH);

  logic [1:0]               r_state;
  logic [TS_W-1:0]          r_ts;
  logic signed [DATA_W-1:0] r_max;
  logic [TS_W-1:0]          r_max_ts;
  logic [7:0]               r_width;
  logic [HC_W-1:0]          r_hcnt;
  logic                     r_valid;
  logic signed [DATA_W-1:0] r_amp;
  logic [TS_W-1:0]          r_time;
  logic [CNT_W-1:0]         r_drop;
`ifdef PEAK_PILEUP_EN
  logic                     r_pileup;
  logic [CNT_W-1:0]         r_pile_cnt;
`endif

  logic w_cross;

  assign w_cross = filter_data > threshold;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_ts       <= '0;
      r_max      <= '0;
      r_max_ts   <= '0;
      r_width    <= '0;
      r_hcnt     <= '0;
      r_valid    <= 1'b0;
      r_amp      <= '0;
      r_time     <= '0;
      r_drop     <= '0;
`ifdef PEAK_PILEUP_EN
      r_pileup   <= 1'b0;
      r_pile_cnt <= '0;
`endif
    end else begin
      r_ts <= r_ts + 1'b1;

      // Acceptance clears the register; a same-cycle emit below overrides.
      if (r_valid && pk.peak_ready) r_valid <= 1'b0;

      if (!enable) begin
        r_state <= S_IDLE;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_cross) begin
              r_state  <= S_ARMED;
              r_max    <= filter_data;
              r_max_ts <= r_ts;
              r_width  <= 8'd1;
            end
          end
          S_ARMED: begin
            if (w_cross) begin
              if (r_width != 8'hFF) r_width <= r_width + 1'b1;
              // Strict compare: on a tie the earlier sample keeps the timestamp.
              if (filter_data > r_max) begin
                r_max    <= filter_data;
                r_max_ts <= r_ts;
              end
            end else if (r_width >= MINW) begin
              r_state <= S_HOLD;
              r_hcnt  <= HOLD_INIT;
              if (!r_valid || pk.peak_ready) begin
                r_valid  <= 1'b1;
                r_amp    <= r_max;
                r_time   <= r_max_ts;
`ifdef PEAK_PILEUP_EN
                r_pileup <= 1'b0;
`endif
              end else if (r_drop != '1) begin
                r_drop <= r_drop + 1'b1;
              end
            end else begin
              r_state <= S_IDLE;
            end
          end
          S_HOLD: begin
            // Expiry wins over a coincident crossing, so that crossing is lost.
            if (r_hcnt == '0) begin
              r_state <= S_IDLE;
            end
`ifdef PEAK_PILEUP_EN
            else if (w_cross) begin
              r_hcnt <= HOLD_INIT;
              if (r_pile_cnt != '1) r_pile_cnt <= r_pile_cnt + 1'b1;
              if (r_valid && !pk.peak_ready) r_pileup <= 1'b1;
            end
`endif
            else begin
              r_hcnt <= r_hcnt - 1'b1;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign pk.peak_valid = r_valid;
  assign pk.peak_amp   = r_amp;
  assign pk.peak_time  = r_time;
  assign drop_cnt      = r_drop;
  assign busy          = (r_state != S_IDLE);
`ifdef PEAK_PILEUP_EN
  assign pk.peak_pileup = r_pileup;
  assign pileup_cnt     = r_pile_cnt;
`else
  assign pk.peak_pileup = 1'b0;
  assign pileup_cnt     = '0;
`endif

endmodule
